// File: rtl/reaction_timer_ctrl_if.sv
// Bundles the reaction-timer controller's game-facing signals.
// The slave side is the controller and the master side is the sequencer/player environment.
interface reaction_timer_ctrl_if #(
  parameter int LFSR_W = 10,
  parameter int CNT_W  = 14
);
  logic              tick_ms;
  logic              start_delay;
  logic [LFSR_W-1:0] lfsr_val;
  logic              button;
  logic              time_out;
  logic [CNT_W-1:0]  reaction_ms;
  logic [CNT_W-1:0]  best_ms;
  logic              result_valid;
  logic              false_start;
  logic              no_response;
  logic              busy;

  modport master (
    output tick_ms, start_delay, lfsr_val, button,
    input  time_out, reaction_ms, best_ms, result_valid, false_start, no_response, busy
  );

  modport slave (
    input  tick_ms, start_delay, lfsr_val, button,
    output time_out, reaction_ms, best_ms, result_valid, false_start, no_response, busy
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Round controller for the reaction-time game. It runs a random hold-off and then
// times the player's press in ms, flagging false starts and no-response rounds.
module reaction_timer_ctrl #(
  parameter int LFSR_W       = 10,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 9999,
  parameter int CNT_W        = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  reaction_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DELAY, TIMING, HOLD} state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DELAY_MS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MS);

  function automatic logic [CNT_W-1:0] holdoff_len(input logic [LFSR_W-1:0] seed);
    return MIN_C + CNT_W'(seed);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_C) ? MAX_C : v + CNT_W'(1);
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] delay_cnt, delay_cnt_n;
  logic [CNT_W-1:0] react_cnt, react_cnt_n;
  logic [CNT_W-1:0] reaction, reaction_n;
  logic [CNT_W-1:0] best, best_n;
  logic             time_out, time_out_n;
  logic             result_valid, result_valid_n;
  logic             false_start, false_start_n;
  logic             no_response, no_response_n;
  logic             btn_q;
  logic             press;

  // Rising edge of the debounced button; btn_q resets low but presses are ignored in IDLE.
  assign press = bus.button & ~btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      delay_cnt    <= '0;
      react_cnt    <= '0;
      reaction     <= '0;
      best         <= MAX_C;
      time_out     <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      no_response  <= 1'b0;
      btn_q        <= 1'b0;
    end else begin
      state        <= state_n;
      delay_cnt    <= delay_cnt_n;
      react_cnt    <= react_cnt_n;
      reaction     <= reaction_n;
      best         <= best_n;
      time_out     <= time_out_n;
      result_valid <= result_valid_n;
      false_start  <= false_start_n;
      no_response  <= no_response_n;
      btn_q        <= bus.button;
    end
  end

  always_comb begin
    state_n        = state;
    delay_cnt_n    = delay_cnt;
    react_cnt_n    = react_cnt;
    reaction_n     = reaction;
    best_n         = best;
    time_out_n     = 1'b0;
    result_valid_n = 1'b0;
    false_start_n  = false_start;
    no_response_n  = no_response;

    case (state)
      IDLE: begin
        if (bus.start_delay) begin
          state_n       = DELAY;
          delay_cnt_n   = holdoff_len(bus.lfsr_val);
          false_start_n = 1'b0;
          no_response_n = 1'b0;
        end
      end

      DELAY: begin
        // A press outranks a coincident tick: the round is a false start.
        if (press) begin
          state_n        = HOLD;
          false_start_n  = 1'b1;
          reaction_n     = '0;
          time_out_n     = 1'b1;
          result_valid_n = 1'b1;
        end else if (bus.tick_ms) begin
          if (delay_cnt <= CNT_W'(1)) begin
            state_n     = TIMING;
            delay_cnt_n = '0;
            react_cnt_n = '0;
            time_out_n  = 1'b1;
          end else begin
            delay_cnt_n = delay_cnt - CNT_W'(1);
          end
        end
      end

      TIMING: begin
        if (press) begin
          state_n        = HOLD;
          reaction_n     = react_cnt;
          result_valid_n = 1'b1;
          if (react_cnt < best) best_n = react_cnt;
        end else if (bus.tick_ms) begin
          react_cnt_n = sat_inc(react_cnt);
          if (react_cnt_n == MAX_C) begin
            state_n        = HOLD;
            reaction_n     = MAX_C;
            no_response_n  = 1'b1;
            result_valid_n = 1'b1;
          end
        end
      end

      HOLD: begin
        // Wait for the light bar to finish exiting before a new round can arm.
        if (!bus.start_delay) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.time_out     = time_out;
  assign bus.reaction_ms  = reaction;
  assign bus.best_ms      = best;
  assign bus.result_valid = result_valid;
  assign bus.false_start  = false_start;
  assign bus.no_response  = no_response;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a shortened hold-off (MIN 4 ms) and limit (MAX 20 ms).
module tb_reaction_timer_ctrl;
  localparam int LFSR_W = 10;
  localparam int CNT_W  = 14;
  localparam int MIN_MS = 4;
  localparam int MAX_MS = 20;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   to_cnt;
  int   rv_cnt;
  int   base_to;
  int   base_rv;

  reaction_timer_ctrl_if #(.LFSR_W(LFSR_W), .CNT_W(CNT_W)) bus ();

  reaction_timer_ctrl #(
    .LFSR_W(LFSR_W), .MIN_DELAY_MS(MIN_MS), .MAX_MS(MAX_MS), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    to_cnt = 0;
    rv_cnt = 0;
  end

  always @(negedge clk) begin
    if (bus.time_out === 1'b1) to_cnt = to_cnt + 1;
    if (bus.result_valid === 1'b1) rv_cnt = rv_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    bus.tick_ms = 1'b1;
    @(posedge clk);
    #1;
    bus.tick_ms = 1'b0;
  endtask

  task automatic start_round(input int seed);
    bus.lfsr_val    = LFSR_W'(seed);
    bus.start_delay = 1'b1;
    step();
  endtask

  task automatic end_round();
    bus.start_delay = 1'b0;
    step();
  endtask

  task automatic wait_holdoff(input int n);
    repeat (n) begin
      tick1();
      step();
    end
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    reset           = 1'b1;
    bus.tick_ms     = 1'b0;
    bus.start_delay = 1'b0;
    bus.lfsr_val    = '0;
    bus.button      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_best", bus.best_ms, MAX_MS);
    chk("rst_reaction", bus.reaction_ms, 0);
    chk("rst_time_out", bus.time_out, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_false_start", bus.false_start, 0);
    chk("rst_no_response", bus.no_response, 0);
    reset = 1'b0;
    step();

    // No press: hold-off of 4+3 ticks, then run to the 20 ms limit.
    start_round(3);
    chk("t1_busy", bus.busy, 1);
    base_to = to_cnt;
    repeat (6) begin
      tick1();
      step();
    end
    chk("t1_no_early_to", to_cnt - base_to, 0);
    tick1();
    chk("t1_to_pulse", bus.time_out, 1);
    step();
    chk("t1_to_low", bus.time_out, 0);
    chk("t1_to_count", to_cnt - base_to, 1);
    base_rv = rv_cnt;
    repeat (19) begin
      tick1();
      step();
    end
    chk("t1_no_early_rv", rv_cnt - base_rv, 0);
    tick1();
    chk("t1_rv", bus.result_valid, 1);
    chk("t1_no_response", bus.no_response, 1);
    chk("t1_reaction", bus.reaction_ms, MAX_MS);
    step();
    chk("t1_rv_count", rv_cnt - base_rv, 1);
    chk("t1_best", bus.best_ms, MAX_MS);
    chk("t1_hold_busy", bus.busy, 1);
    end_round();
    chk("t1_idle", bus.busy, 0);

    // Valid presses: 5 ms sets the best, 8 ms does not.
    start_round(3);
    chk("t2_nr_cleared", bus.no_response, 0);
    wait_holdoff(7);
    repeat (5) begin
      tick1();
      step();
    end
    bus.button = 1'b1;
    step();
    chk("t2_rv", bus.result_valid, 1);
    chk("t2_reaction5", bus.reaction_ms, 5);
    chk("t2_best5", bus.best_ms, 5);
    bus.button = 1'b0;
    step();
    chk("t2_rv_low", bus.result_valid, 0);
    end_round();
    start_round(5);
    wait_holdoff(9);
    repeat (8) begin
      tick1();
      step();
    end
    bus.button = 1'b1;
    step();
    chk("t2_reaction8", bus.reaction_ms, 8);
    chk("t2_best_kept", bus.best_ms, 5);
    bus.button = 1'b0;
    step();
    end_round();

    // False start during the hold-off.
    start_round(2);
    repeat (2) begin
      tick1();
      step();
    end
    bus.button = 1'b1;
    step();
    chk("t3_false_start", bus.false_start, 1);
    chk("t3_reaction0", bus.reaction_ms, 0);
    chk("t3_to", bus.time_out, 1);
    chk("t3_rv", bus.result_valid, 1);
    chk("t3_best", bus.best_ms, 5);
    bus.button = 1'b0;
    step();
    end_round();
    start_round(0);
    chk("t3_fs_cleared", bus.false_start, 0);

    // Press coinciding with a tick, in TIMING then in DELAY.
    wait_holdoff(4);
    repeat (6) begin
      tick1();
      step();
    end
    bus.tick_ms = 1'b1;
    bus.button  = 1'b1;
    step();
    bus.tick_ms = 1'b0;
    chk("t4_rv", bus.result_valid, 1);
    chk("t4_reaction6", bus.reaction_ms, 6);
    chk("t4_best", bus.best_ms, 5);
    bus.button = 1'b0;
    step();
    end_round();
    start_round(1);
    tick1();
    step();
    bus.tick_ms = 1'b1;
    bus.button  = 1'b1;
    step();
    bus.tick_ms = 1'b0;
    chk("t4_fs", bus.false_start, 1);
    chk("t4_fs_to", bus.time_out, 1);
    chk("t4_fs_reaction", bus.reaction_ms, 0);
    bus.button = 1'b0;
    step();

    // HOLD persists while start_delay stays high; re-arm samples a fresh seed.
    base_rv = rv_cnt;
    repeat (3) step();
    chk("t5_hold_busy", bus.busy, 1);
    chk("t5_no_rv", rv_cnt - base_rv, 0);
    end_round();
    chk("t5_idle", bus.busy, 0);
    start_round(0);
    base_to = to_cnt;
    repeat (3) begin
      tick1();
      step();
    end
    chk("t5_no_early_to", to_cnt - base_to, 0);
    tick1();
    chk("t5_to_after4", bus.time_out, 1);
    step();

    // Reset in TIMING with the button held, then a fresh press after release.
    repeat (2) begin
      tick1();
      step();
    end
    base_rv    = rv_cnt;
    base_to    = to_cnt;
    bus.button = 1'b1;
    reset      = 1'b1;
    step();
    chk("t6_busy", bus.busy, 0);
    chk("t6_best", bus.best_ms, MAX_MS);
    chk("t6_reaction", bus.reaction_ms, 0);
    chk("t6_rv", bus.result_valid, 0);
    chk("t6_to", bus.time_out, 0);
    chk("t6_fs", bus.false_start, 0);
    step();
    reset = 1'b0;
    step();
    chk("t6_rearm", bus.busy, 1);
    repeat (3) step();
    chk("t6_held_no_press", bus.false_start, 0);
    chk("t6_no_rv", rv_cnt - base_rv, 0);
    chk("t6_no_to", to_cnt - base_to, 0);
    bus.button = 1'b0;
    step();
    bus.button = 1'b1;
    step();
    chk("t6_new_press", bus.false_start, 1);
    chk("t6_new_rv", bus.result_valid, 1);
    bus.button      = 1'b0;
    bus.start_delay = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Round controller for the reaction-time game. It waits for the light-bar sequencer to assert start_delay, then runs a pseudo-random hold-off (MIN_DELAY_MS + lfsr_val ms). At the end of the hold-off it pulses time_out, which returns the light bar to IDLE with the LEDs dark. It then measures the time in ms until the player presses, and tracks the best time. Button presses during the hold-off are detected and flagged as false starts.

Parameters:
LFSR_W, 10, width of random seed input lfsr_val
MIN_DELAY_MS, 1000, fixed part of hold-off in ms
MAX_MS, 9999, reaction counter saturation / no-response limit in ms
CNT_W, 14, width of all ms counters; constraint: MIN_DELAY_MS + 2^LFSR_W - 1 <= 2^CNT_W - 1 and MAX_MS <= 2^CNT_W - 1

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
tick_ms  in  1  one-clk-wide strobe, once per ms
start_delay  in  1  level from light-bar sequencer; high once the bar is full
lfsr_val  in  LFSR_W  random value, sampled once per round
button  in  1  player button, already synchronised/debounced, active-high level
time_out  out  1  1-clk pulse telling the light-bar sequencer to go dark/IDLE
reaction_ms  out  CNT_W  last measured reaction time in ms, held until the next result
best_ms  out  CNT_W  smallest valid reaction_ms since reset
result_valid  out  1  1-clk pulse when reaction_ms, false_start and no_response update
false_start  out  1  last round ended by a press during the hold-off; held until the next round starts
no_response  out  1  last round hit MAX_MS with no press; held until the next round starts
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, overrides all): state=IDLE; time_out=0, result_valid=0, reaction_ms=0, best_ms=MAX_MS, false_start=0, no_response=0, busy=0; delay_cnt=0, react_cnt=0, btn_q=0.
- Press detection: press = button & ~btn_q, with btn_q registered every cycle. A button held through reset produces no press.
- States: IDLE, DELAY, TIMING, HOLD.
- IDLE: when start_delay==1, go to DELAY.
  - delay_cnt <= MIN_DELAY_MS + zero-extended lfsr_val.
  - Clear false_start and no_response.
- DELAY:
  - If press: go to HOLD; false_start<=1; reaction_ms<=0; time_out and result_valid pulse the next cycle. Press has priority over a simultaneous tick_ms.
  - Else on tick_ms: delay_cnt decrements. On the tick where delay_cnt==1: go to TIMING, react_cnt<=0, time_out pulses one cycle.
  - The hold-off is therefore exactly delay_cnt ticks.
- TIMING:
  - If press: go to HOLD; reaction_ms<=react_cnt, using the pre-increment value if tick_ms coincides; result_valid pulses. If react_cnt < best_ms then best_ms<=react_cnt; equal values do not update.
  - Else on tick_ms: react_cnt increments. If the incremented value equals MAX_MS: go to HOLD; reaction_ms<=MAX_MS; no_response<=1; result_valid pulses; best_ms unchanged.
- HOLD: stay until start_delay==0, then go to IDLE. This prevents a re-trigger while the light bar is still exiting.
- Output timing: time_out and result_valid are registered, exactly one clk wide, and never asserted in IDLE.
- Reset mid-round: immediate return to IDLE; no time_out or result_valid pulse is emitted.
- start_delay dropping during DELAY or TIMING is ignored; the round completes.
- Sampling: lfsr_val is sampled only on the IDLE->DELAY transition.

Test Plan:
1. Bench parameters MIN_DELAY_MS=4, MAX_MS=20, lfsr_val=3 at trigger; raise start_delay, no press -> time_out pulses on the cycle after the 7th tick_ms; no_response=1, reaction_ms=20, result_valid once; best_ms stays 20.
2. Same setup; press 5 ticks after time_out -> reaction_ms=5, best_ms=5, result_valid one clk. Next round with press after 8 ticks -> reaction_ms=8, best_ms stays 5.
3. Press during DELAY after 2 ticks -> false_start=1, reaction_ms=0, time_out and result_valid pulse together; best_ms unchanged. Next IDLE->DELAY clears false_start.
4. Press and tick_ms in the same cycle in TIMING with react_cnt=6 -> reaction_ms=6. Press and tick_ms together in DELAY -> false start is taken, not a decrement.
5. Hold start_delay=1 after a result -> controller stays in HOLD with busy=1. Drop start_delay -> IDLE next cycle. Raise it again -> new round with fresh lfsr_val.
6. Assert reset during TIMING -> next cycle IDLE, all outputs at reset values, best_ms=MAX_MS, no pulses. Button held high across reset, then released and pressed -> only the new press is detected.
